c_fetch_buffer: RTL

Halfword-granular instruction fetch buffer for the compressed-extension front end. Sits between the instruction cache and the decode/decompress stage: it issues word-aligned fetches, stores returned data as 16-bit parcels in a circular queue, and presents one complete instruction per handshake. Each instruction is 16-bit compressed or 32-bit, may start at any halfword, and may straddle two fetch words. The instruction's PC is presented with it, so downstream never handles misalignment.

---
 rtl/c_ext_pkg.sv | 13 +
 rtl/c_hw_queue.sv | 67 ++++++
 rtl/c_fetch_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/c_ext_pkg.sv
// Shared definitions for the compressed-extension front end.
// Parcel sizes, the canonical c.nop encoding and the length decoder.
package c_ext_pkg;

  localparam int unsigned ILEN_HW = 2;

  localparam logic [31:0] C_NOP = 32'h0000_0001;

  function automatic logic is_compressed(logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/c_hw_queue.sv
// Circular queue of 16-bit parcels: 0/1/2 pushes and pops per cycle,
// synchronous clear, and read ports at the head and the parcel after it.
module c_hw_queue #(
  parameter int unsigned DEPTH_HW = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH_HW),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [1:0]       push_num,
  input  logic [15:0]      push_hw0,
  input  logic [15:0]      push_hw1,
  input  logic [1:0]       pop_num,
  output logic [15:0]      head_hw,
  output logic [15:0]      next_hw,
  output logic [CNT_W-1:0] count
);

  logic [15:0]      mem_q [DEPTH_HW];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers are exactly log2(depth) wide, so increments wrap for free.
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

  assign head_hw = mem_q[rd_ptr_q];
  assign next_hw = mem_q[rd_ptr_nxt];
  assign count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_num);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_num);
    count_d  = count_q + CNT_W'(push_num) - CNT_W'(pop_num);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read out before count says it is valid.
  always_ff @(posedge clk) begin
    if (!clear && push_num != 2'd0) begin
      mem_q[wr_ptr_q] <= push_hw0;
    end
    if (!clear && push_num == 2'd2) begin
      mem_q[wr_ptr_nxt] <= push_hw1;
    end
  end

endmodule

// File: rtl/c_fetch_buffer.sv
// Halfword-granular fetch buffer: word fetches in, one aligned 16/32-bit
// instruction with its PC out per handshake.
module c_fetch_buffer
  import c_ext_pkg::*;
#(
  parameter int unsigned DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH_HW) + 1;
  localparam logic [CNT_W-1:0] REQ_MAX = CNT_W'(DEPTH_HW - ILEN_HW);

  logic [31:0]      head_pc_q, head_pc_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_low_q, drop_low_d;
  logic             discard_q, discard_d;

  logic             q_clear;
  logic [1:0]       push_num, pop_num;
  logic [15:0]      push_hw0, push_hw1;
  logic [15:0]      head_hw, next_hw;
  logic [CNT_W-1:0] count;

  logic             head_c, has_one, has_two, fire;
  logic             unused_redirect_lsb;

  c_hw_queue #(
    .DEPTH_HW (DEPTH_HW)
  ) u_queue (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (q_clear),
    .push_num (push_num),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .pop_num  (pop_num),
    .head_hw  (head_hw),
    .next_hw  (next_hw),
    .count    (count)
  );

  assign unused_redirect_lsb = redirect_pc_i[0];

  assign head_c  = is_compressed(head_hw);
  assign has_one = count != '0;
  assign has_two = count >= CNT_W'(2);

  assign inst_valid_o    = head_c ? has_one : has_two;
  assign is_compressed_o = has_one && head_c;
  assign inst_o          = !inst_valid_o ? '0 :
                           head_c        ? {16'h0000, head_hw} : {next_hw, head_hw};
  assign pc_o            = head_pc_q;
  assign fire            = inst_valid_o && inst_ready_i;

  // Gated by reset so no request escapes while the block is held in reset.
  assign icache_addr_o = fetch_pc_q;
  assign icache_req_o  = reset && !outstanding_q && !redirect_i && (count <= REQ_MAX);

  always_comb begin
    head_pc_d     = head_pc_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_low_d    = drop_low_q;
    discard_d     = discard_q;
    q_clear       = 1'b0;
    push_num      = 2'd0;
    push_hw0      = icache_data_i[15:0];
    push_hw1      = icache_data_i[31:16];
    pop_num       = 2'd0;

    if (redirect_i) begin
      q_clear       = 1'b1;
      head_pc_d     = {redirect_pc_i[31:1], 1'b0};
      fetch_pc_d    = {redirect_pc_i[31:2], 2'b00};
      drop_low_d    = redirect_pc_i[1];
      // A fetch still in flight belongs to the old stream; swallow it on return.
      outstanding_d = outstanding_q && !icache_valid_i;
      discard_d     = outstanding_q && !icache_valid_i;
    end else begin
      if (icache_valid_i) begin
        outstanding_d = 1'b0;
        if (discard_q) begin
          discard_d = 1'b0;
        end else begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          drop_low_d = 1'b0;
          if (drop_low_q) begin
            push_num = 2'd1;
            push_hw0 = icache_data_i[31:16];
          end else begin
            push_num = 2'd2;
          end
        end
      end
      if (icache_req_o) begin
        outstanding_d = 1'b1;
      end
      if (fire) begin
        pop_num   = head_c ? 2'd1 : 2'(ILEN_HW);
        head_pc_d = head_pc_q + (head_c ? 32'd2 : 32'd4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_pc_q     <= RESET_PC;
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      outstanding_q <= 1'b0;
      drop_low_q    <= RESET_PC[1];
      discard_q     <= 1'b0;
    end else begin
      head_pc_q     <= head_pc_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_low_q    <= drop_low_d;
      discard_q     <= discard_d;
    end
  end

endmodule
